// File: rtl/tx_pkg.sv
// Shared definitions for the serial transmit path: default frame geometry and the
// state encodings used by the arbiter and the frame controllers.
package tx_pkg;

   localparam int unsigned TX_WIDTH = 12;
   localparam int unsigned TX_CNT_W = 4;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StArb   = 3'd1;
   localparam logic [2:0] StLoad  = 3'd2;
   localparam logic [2:0] StShift = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1,
// wrapping at N_REQ-1 back to 0.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned SW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [SW-1:0]    last,
   output logic [N_REQ-1:0] grant,
   output logic [SW-1:0]    idx,
   output logic             any
);

   int unsigned p;
   logic        found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      p     = 0;
      any   = |req;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         p = 32'(last) + k;
         if (p >= N_REQ) p = p - N_REQ;
         if (!found && req[p]) begin
            found    = 1'b1;
            idx      = p[SW-1:0];
            grant[p] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_round_robin_arbiter.sv
// Round-robin owner of the shared transmit shift register: picks a requester, loads its
// word, shifts WIDTH bits, then strobes TXRDY with an ACK to the grantee.
module tx_round_robin_arbiter
   import tx_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = TX_WIDTH,
   parameter int unsigned CNT_W = TX_CNT_W
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [N_REQ-1:0]       REQ,
   input  logic [N_REQ*WIDTH-1:0] DATE,
   output logic [N_REQ-1:0]       GNT,
   output logic [N_REQ-1:0]       ACK,
   output logic                   INCARCA,
   output logic                   DEPL,
   output logic [WIDTH-1:0]       DATE_TX,
   output logic                   TXRDY,
   output logic                   BUSY
);

   localparam int unsigned SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    sel_q, sel_d;
   logic [SW-1:0]    last_q, last_d;
   logic [WIDTH-1:0] data_d, data_sel;
   logic [N_REQ-1:0] sel_oh_q, gnt_d, ack_d;
   logic [N_REQ-1:0] pick_grant;
   logic [SW-1:0]    pick_idx;
   logic             pick_any;

   rr_pick #(
      .N_REQ (N_REQ),
      .SW    (SW)
   ) u_pick (
      .req   (REQ),
      .last  (last_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      data_sel = '0;
      sel_oh_q = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (pick_idx == SW'(i)) data_sel = DATE[i*WIDTH +: WIDTH];
         if (sel_q == SW'(i)) sel_oh_q[i] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      data_d  = DATE_TX;
      case (state_q)
         StIdle: if (|REQ) state_d = StArb;
         StArb: begin
            if (pick_any) begin
               sel_d   = pick_idx;
               data_d  = data_sel;
               state_d = StLoad;
            end else begin
               state_d = StIdle;
            end
         end
         StLoad: begin
            cnt_d   = '0;
            state_d = StShift;
         end
         StShift: begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            last_d = sel_q;
            // The grantee's own REQ is still high here; it must not trigger a resend.
            state_d = (|(REQ & ~sel_oh_q)) ? StArb : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      gnt_d = '0;
      ack_d = '0;
      if (state_d == StLoad) gnt_d = pick_grant;
      else if (state_d == StShift || state_d == StDone) gnt_d = sel_oh_q;
      if (state_d == StDone) ack_d = sel_oh_q;
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= SW'(N_REQ - 1);
         GNT     <= '0;
         ACK     <= '0;
         INCARCA <= 1'b0;
         DEPL    <= 1'b0;
         DATE_TX <= '0;
         TXRDY   <= 1'b0;
         BUSY    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         GNT     <= gnt_d;
         ACK     <= ack_d;
         INCARCA <= (state_d == StLoad);
         DEPL    <= (state_d == StShift);
         DATE_TX <= data_d;
         TXRDY   <= (state_d == StDone);
         BUSY    <= (state_d != StIdle);
      end
   end

endmodule

// File: tb/tb_tx_round_robin_arbiter.sv
// Directed bench for tx_round_robin_arbiter with hand-computed frame timing and grants.
module tb_tx_round_robin_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [3:0]  REQ;
   logic [47:0] DATE;
   logic [3:0]  GNT, ACK;
   logic        INCARCA, DEPL, TXRDY, BUSY;
   logic [11:0] DATE_TX;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int last_wait, load_cyc;
   int loads[4];
   logic [11:0] dw[4];

   tx_round_robin_arbiter #(
      .N_REQ (4),
      .WIDTH (12),
      .CNT_W (4)
   ) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .REQ     (REQ),
      .DATE    (DATE),
      .GNT     (GNT),
      .ACK     (ACK),
      .INCARCA (INCARCA),
      .DEPL    (DEPL),
      .DATE_TX (DATE_TX),
      .TXRDY   (TXRDY),
      .BUSY    (BUSY)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One full frame for requester idx; mid_clr/mid_set modify REQ five cycles into SHIFT.
   task automatic frame(input string tag, input int idx, input logic [3:0] mid_clr,
                        input logic [3:0] mid_set, input bit drop);
      int n, nd;
      n = 0;
      while (INCARCA !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      last_wait = n;
      load_cyc  = cyc;
      chk({tag, ".load"}, 32'(INCARCA), 32'd1);
      if (INCARCA !== 1'b1) return;
      chk({tag, ".gnt"}, 32'(GNT), 32'(1 << idx));
      chk({tag, ".data"}, 32'(DATE_TX), 32'(dw[idx]));
      chk({tag, ".depl_at_load"}, 32'(DEPL), 32'd0);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (DEPL === 1'b1 && INCARCA === 1'b0 && TXRDY === 1'b0) nd++;
         if (i == 4) REQ = (REQ & ~mid_clr) | mid_set;
      end
      chk({tag, ".depl_cnt"}, 32'(nd), 32'd12);
      tick();
      chk({tag, ".txrdy"}, 32'(TXRDY), 32'd1);
      chk({tag, ".ack"}, 32'(ACK), 32'(1 << idx));
      chk({tag, ".done_depl"}, 32'(DEPL), 32'd0);
      if (drop) begin
         tick();
         REQ[idx] = 1'b0;
      end
   endtask

   initial begin
      dw[0] = 12'h0E7;
      dw[1] = 12'h1F0;
      dw[2] = 12'hA5C;
      dw[3] = 12'h3C3;
      DATE  = {dw[3], dw[2], dw[1], dw[0]};
      REQ   = '0;
      RESET = 1'b0;
      tick();
      tick();
      chk("rst.outs", {GNT, ACK, INCARCA, DEPL, TXRDY, BUSY, 12'(DATE_TX)}, 32'd0);
      RESET = 1'b1;
      tick();

      // Single request from 2: LOAD two cycles after REQ, then back to IDLE.
      REQ = 4'b0100;
      frame("t2", 2, 4'b0, 4'b0, 1'b1);
      chk("t2.latency", 32'(last_wait), 32'd2);
      chk("t2.idle", 32'(BUSY), 32'd0);

      // Reset mid-SHIFT aborts the frame of requester 3; pointer returns to 3 so 0 wins.
      REQ = 4'b1000;
      for (int n = 0; n < 40 && INCARCA !== 1'b1; n++) tick();
      chk("t1.started", 32'(INCARCA), 32'd1);
      tick();
      tick();
      tick();
      RESET = 1'b0;
      tick();
      chk("t1.outs", {GNT, ACK, INCARCA, DEPL, TXRDY, BUSY, 12'(DATE_TX)}, 32'd0);
      tick();
      chk("t1.no_ack", {ACK, TXRDY, BUSY}, 32'd0);
      REQ   = 4'b1001;
      RESET = 1'b1;
      frame("t1a", 0, 4'b0, 4'b0, 1'b1);
      frame("t1b", 3, 4'b0, 4'b0, 1'b1);

      // All four requesting: served 0,1,2,3; LOAD spacing is ARB+LOAD+12 SHIFT+DONE = 15.
      REQ = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         frame($sformatf("t3.%0d", i), i, 4'b0, 4'b0, 1'b1);
         loads[i] = load_cyc;
      end
      for (int i = 1; i < 4; i++)
         chk($sformatf("t3.period%0d", i), 32'(loads[i] - loads[i-1]), 32'd15);
      chk("t3.idle", 32'(BUSY), 32'd0);

      // REQ still high through DONE must not cause a second frame.
      REQ = 4'b0001;
      frame("t4", 0, 4'b0, 4'b0, 1'b0);
      tick();
      REQ = 4'b0000;
      chk("t4.busy1", 32'(BUSY), 32'd0);
      tick();
      chk("t4.busy2", {BUSY, INCARCA}, 32'd0);

      // Withdraw mid-SHIFT still completes; late REQ[3] is served next.
      tick();
      REQ = 4'b0010;
      frame("t5a", 1, 4'b0010, 4'b1000, 1'b1);
      frame("t5b", 3, 4'b0, 4'b0, 1'b1);
      chk("t5.next_load_wait", 32'(last_wait), 32'd1);
      chk("t5.idle", 32'(BUSY), 32'd0);

      // One-cycle pulse: ARB sees nothing and falls back to IDLE without a grant.
      tick();
      REQ = 4'b0001;
      tick();
      REQ = 4'b0000;
      chk("t6.arb", {BUSY, GNT, INCARCA}, 32'h20);
      tick();
      chk("t6.idle", {BUSY, GNT, INCARCA}, 32'd0);
      tick();
      chk("t6.no_load", {GNT, INCARCA, DEPL}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
